clk_div_prog: RTL and testbench
===============================

# clk_div_prog

Runtime-programmable integer clock divider, replacing the fixed divide-by-6 block. It produces a registered divided clock with a programmable period and high time, plus a one-cycle period-start tick. It sits beside the system clock generator and feeds slow peripheral timing and enables. New ratios are loaded through a valid/ready handshake and take effect only at a period boundary, so the output never glitches.

## Interface
- CNT_W, 8: width of counter and ratio fields; max ratio 2^CNT_W−1
- DEF_DIV, 6: period in i_clk cycles after reset; elaboration check DEF_DIV ≥ 2
- DEF_HIGH, 3: high-phase length after reset; elaboration check 1 ≤ DEF_HIGH < DEF_DIV
- i_clk  in  1  single clock; all logic on its rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_en  in  1  run enable
- i_cfg_vld  in  1  new configuration valid
- o_cfg_rdy  out  1  configuration accepted when i_cfg_vld && o_cfg_rdy
- i_cfg_div  in  CNT_W  requested period
- i_cfg_high  in  CNT_W  requested high-phase length
- o_cfg_err  out  1  one-cycle pulse: accepted configuration was illegal
- o_div_clk  out  1  divided clock, registered
- o_tick  out  1  one-cycle pulse on each o_div_clk period start, registered
- o_cur_div  out  CNT_W  active period, for status readback

## Operation
- Reset values:
  - cnt = 0, div_act = DEF_DIV, high_act = DEF_HIGH.
  - Pending slot empty.
  - o_div_clk = 0, o_tick = 0, o_cfg_err = 0, o_cfg_rdy = 1.
- Counter behaviour:
  - i_en = 1: cnt counts 0 .. div_act−1, then wraps to 0.
  - i_en = 0: cnt is forced to 0.
- o_div_clk ← i_en && (cnt < high_act). The output is high for high_act cycles and low for div_act−high_act cycles.
- o_tick ← i_en && (cnt == 0). It coincides with every o_div_clk rising edge.
- Wrap compare: cnt == div_act−1 in CNT_W bits. No underflow is possible because div_act ≥ 2.
- Configuration handshake:
  - o_cfg_rdy = !pending.
  - On acceptance, the legality check runs. A configuration is legal when div ≥ 2 and 1 ≤ high < div.
  - Legal: the values are stored in the pending slot, and o_cfg_rdy drops on the next cycle.
  - Illegal: o_cfg_err pulses on the next cycle. Further handling depends on DIV_CFG_CLAMP_EN (see Configuration).
- Apply rule:
  - Pending values load into div_act and high_act on the edge where i_en && cnt == div_act−1; cnt goes to 0 on the same edge.
  - If i_en = 0, pending values load on the next edge.
  - The pending slot clears on the apply edge, so o_cfg_rdy is 1 on the following cycle.
- Simultaneous acceptance and wrap: the accepted configuration goes into the pending slot and applies at the *next* wrap, not the current one.
- i_en falling mid-period: o_div_clk = 0 and cnt = 0 after one edge. A pending configuration then applies on that same edge.
- i_en rising: the period restarts from cnt 0, giving a full high phase. o_div_clk and o_tick are both 1 after the first enabled edge.
- Asynchronous reset mid-operation: all state returns to reset values immediately, and any pending configuration is discarded.

## Timing
- Enable-to-output latency: 1 cycle. Configuration-to-output latency: at most one full period plus 1 cycle.
- o_div_clk and o_tick lag cnt by exactly one register stage.
- Outputs have no combinational paths from inputs, except o_cfg_rdy, which comes from the pending register.
- o_cur_div changes on the apply edge.

## Configuration
- DIV_CFG_CLAMP_EN defined:
  - An illegal accepted configuration is clamped: div < 2 becomes 2, high = 0 becomes 1, high ≥ div becomes div−1.
  - The clamped values are stored as pending and applied normally.
  - o_cfg_err still pulses.
- DIV_CFG_CLAMP_EN undefined:
  - An illegal configuration is discarded: the pending slot is untouched and the active ratio is unchanged.
  - o_cfg_rdy stays 1 and o_cfg_err pulses.

## Structure
- Shared package clk_div_pkg holds the CNT_W default, a cfg struct {div, high}, and the legality/clamp function.
- One sub-module, clk_div_cfg, owns the handshake, legality check, clamp/discard and the pending slot. It delivers apply values to the counter/output logic in clk_div_prog.

## Test plan
- Reset, i_en = 1, no configuration -> o_div_clk repeats 1,1,1,0,0,0; o_tick every 6 cycles; o_cur_div = 6.
- Configuration div = 5, high = 2 sent at cnt = 1 -> o_cfg_rdy low until the wrap; the current period completes as 3/3; the next periods are 1,1,0,0,0; o_cur_div = 5.
- i_en dropped at cnt = 1, held 4 cycles, raised -> o_div_clk 0 one edge after the drop; after re-enable a full 3-cycle high phase, with o_tick on the first enabled edge.
- Configuration div = 1, high = 1 -> o_cfg_err one pulse.
  - Without macro: the pattern stays 6/3.
  - With macro: the pattern becomes 1,0 repeating.
- Configuration accepted on the wrap edge, plus a second i_cfg_vld while pending -> the first applies one period later; the second is held off (o_cfg_rdy = 0) and accepted after the apply.
- Async reset asserted while a configuration is pending -> all outputs go to reset values immediately; after release the pattern is 6/3 and the pending configuration is lost.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider: default counter width,
// the {div, high} configuration record and its legality / clamp rules.
package clk_div_pkg;

  localparam int CNT_W_DEF = 8;
  // Configuration records are carried at a fixed width so one function set serves any CNT_W.
  localparam int CFG_W     = 32;

  typedef struct packed {
    logic [CFG_W-1:0] div;
    logic [CFG_W-1:0] high;
  } cfg_t;

  function automatic logic cfg_legal(input cfg_t c);
    return (c.div >= 2) && (c.high >= 1) && (c.high < c.div);
  endfunction

  function automatic cfg_t cfg_clamp(input cfg_t c);
    cfg_t r;
    r = c;
    if (r.div < 2) r.div = 2;
    if (r.high == '0) r.high = 1;
    if (r.high >= r.div) r.high = r.div - 1;
    return r;
  endfunction

endpackage

// File: rtl/clk_div_cfg.sv
// Configuration front end: valid/ready handshake, legality check and single pending slot.
// Build option DIV_CFG_CLAMP_EN: illegal requests are clamped and kept rather than dropped.
module clk_div_cfg
  import clk_div_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_cfg_vld,
  output logic             o_cfg_rdy,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic [CNT_W-1:0] i_cfg_high,
  output logic             o_cfg_err,
  input  logic             i_apply,
  output logic             o_pend_vld,
  output logic [CNT_W-1:0] o_pend_div,
  output logic [CNT_W-1:0] o_pend_high
);

  logic             pend_vld_reg,  pend_vld_next;
  logic [CNT_W-1:0] pend_div_reg,  pend_div_next;
  logic [CNT_W-1:0] pend_high_reg, pend_high_next;
  logic             err_reg,       err_next;
  logic             accept;
  logic             legal;
  cfg_t             req;

  assign req    = '{div: CFG_W'(i_cfg_div), high: CFG_W'(i_cfg_high)};
  assign legal  = cfg_legal(req);
  assign accept = i_cfg_vld && !pend_vld_reg;

`ifdef DIV_CFG_CLAMP_EN
  cfg_t fixed;
  logic unused_fixed_bits;
  assign fixed             = cfg_clamp(req);
  assign unused_fixed_bits = ^fixed;
`endif

  // Accept and apply are mutually exclusive: accept needs an empty slot, apply a full one.
  always_comb begin
    pend_vld_next  = pend_vld_reg;
    pend_div_next  = pend_div_reg;
    pend_high_next = pend_high_reg;
    err_next       = accept && !legal;
    if (i_apply) pend_vld_next = 1'b0;
    if (accept) begin
`ifdef DIV_CFG_CLAMP_EN
      pend_vld_next  = 1'b1;
      pend_div_next  = fixed.div[CNT_W-1:0];
      pend_high_next = fixed.high[CNT_W-1:0];
`else
      if (legal) begin
        pend_vld_next  = 1'b1;
        pend_div_next  = i_cfg_div;
        pend_high_next = i_cfg_high;
      end
`endif
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      pend_vld_reg  <= 1'b0;
      pend_div_reg  <= '0;
      pend_high_reg <= '0;
      err_reg       <= 1'b0;
    end else begin
      pend_vld_reg  <= pend_vld_next;
      pend_div_reg  <= pend_div_next;
      pend_high_reg <= pend_high_next;
      err_reg       <= err_next;
    end
  end

  assign o_cfg_rdy   = !pend_vld_reg;
  assign o_cfg_err   = err_reg;
  assign o_pend_vld  = pend_vld_reg;
  assign o_pend_div  = pend_div_reg;
  assign o_pend_high = pend_high_reg;

endmodule

// File: rtl/clk_div_prog.sv
// Runtime-programmable integer clock divider with registered divided clock and period tick.
// Build option DIV_CFG_CLAMP_EN (handled in clk_div_cfg) clamps illegal ratios instead of dropping them.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int DEF_DIV  = 6,
  parameter int DEF_HIGH = 3
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic             i_cfg_vld,
  output logic             o_cfg_rdy,
  input  logic [CNT_W-1:0] i_cfg_div,
  input  logic [CNT_W-1:0] i_cfg_high,
  output logic             o_cfg_err,
  output logic             o_div_clk,
  output logic             o_tick,
  output logic [CNT_W-1:0] o_cur_div
);

  generate
    if (CNT_W < 2 || CNT_W > CFG_W) begin : g_bad_width
      $error("clk_div_prog: CNT_W out of range");
    end
    if (DEF_DIV < 2 || DEF_DIV >= (2 ** CNT_W)) begin : g_bad_div
      $error("clk_div_prog: DEF_DIV must be >= 2 and fit CNT_W");
    end
    if (DEF_HIGH < 1 || DEF_HIGH >= DEF_DIV) begin : g_bad_high
      $error("clk_div_prog: DEF_HIGH must satisfy 1 <= DEF_HIGH < DEF_DIV");
    end
  endgenerate

  logic [CNT_W-1:0] cnt_reg,      cnt_next;
  logic [CNT_W-1:0] div_act_reg,  div_act_next;
  logic [CNT_W-1:0] high_act_reg, high_act_next;
  logic             div_clk_reg,  div_clk_next;
  logic             tick_reg,     tick_next;
  logic             wrap;
  logic             apply;
  logic             pend_vld;
  logic [CNT_W-1:0] pend_div;
  logic [CNT_W-1:0] pend_high;

  clk_div_cfg #(
    .CNT_W (CNT_W)
  ) u_cfg (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_cfg_vld   (i_cfg_vld),
    .o_cfg_rdy   (o_cfg_rdy),
    .i_cfg_div   (i_cfg_div),
    .i_cfg_high  (i_cfg_high),
    .o_cfg_err   (o_cfg_err),
    .i_apply     (apply),
    .o_pend_vld  (pend_vld),
    .o_pend_div  (pend_div),
    .o_pend_high (pend_high)
  );

  // div_act is always >= 2, so the minus-one cannot underflow.
  assign wrap  = (cnt_reg == (div_act_reg - CNT_W'(1)));
  // Ratios change only where the counter restarts, so no runt high or low phase is produced.
  assign apply = pend_vld && (!i_en || wrap);

  always_comb begin
    cnt_next      = cnt_reg + CNT_W'(1);
    div_act_next  = div_act_reg;
    high_act_next = high_act_reg;
    if (!i_en || wrap) cnt_next = '0;
    if (apply) begin
      div_act_next  = pend_div;
      high_act_next = pend_high;
    end
    div_clk_next = i_en && (cnt_reg < high_act_reg);
    tick_next    = i_en && (cnt_reg == '0);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_reg      <= '0;
      div_act_reg  <= CNT_W'(DEF_DIV);
      high_act_reg <= CNT_W'(DEF_HIGH);
      div_clk_reg  <= 1'b0;
      tick_reg     <= 1'b0;
    end else begin
      cnt_reg      <= cnt_next;
      div_act_reg  <= div_act_next;
      high_act_reg <= high_act_next;
      div_clk_reg  <= div_clk_next;
      tick_reg     <= tick_next;
    end
  end

  assign o_div_clk = div_clk_reg;
  assign o_tick    = tick_reg;
  assign o_cur_div = div_act_reg;

endmodule

// File: tb/tb_clk_div_prog.sv
// Scoreboard bench for clk_div_prog: the reference model builds each output period as a
// waveform queue and pushes expected per-cycle outputs; a monitor pops and compares.
module tb_clk_div_prog;

  localparam int CNT_W    = 8;
  localparam int DEF_DIV  = 6;
  localparam int DEF_HIGH = 3;

  logic             i_clk = 1'b0;
  logic             i_rst_n;
  logic             i_en;
  logic             i_cfg_vld;
  logic [CNT_W-1:0] i_cfg_div;
  logic [CNT_W-1:0] i_cfg_high;
  logic             o_cfg_rdy;
  logic             o_cfg_err;
  logic             o_div_clk;
  logic             o_tick;
  logic [CNT_W-1:0] o_cur_div;

  clk_div_prog #(
    .CNT_W    (CNT_W),
    .DEF_DIV  (DEF_DIV),
    .DEF_HIGH (DEF_HIGH)
  ) dut (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_en       (i_en),
    .i_cfg_vld  (i_cfg_vld),
    .o_cfg_rdy  (o_cfg_rdy),
    .i_cfg_div  (i_cfg_div),
    .i_cfg_high (i_cfg_high),
    .o_cfg_err  (o_cfg_err),
    .o_div_clk  (o_div_clk),
    .o_tick     (o_tick),
    .o_cur_div  (o_cur_div)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    bit ck;
    bit tk;
    bit err;
    bit rdy;
    int cur;
  } exp_t;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: active ratio, pending slot, and the remaining samples of the current period.
  int       m_div, m_high, m_pd, m_ph;
  bit       m_pv;
  bit [1:0] wave[$];  // {tick, clk}

  function automatic void chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_reset();
    m_div  = DEF_DIV;
    m_high = DEF_HIGH;
    m_pv   = 1'b0;
    m_pd   = 0;
    m_ph   = 0;
    wave.delete();
  endfunction

  // Called just after a falling edge; drives inputs for the next rising edge and predicts its outputs.
  task automatic step(input bit en, input bit vld, input int d_in, input int h_in, output bit acc);
    exp_t     e;
    bit [1:0] smp;
    bit       legal;
    bit       do_apply;
    int       d, h, nd, nh;
    #1;
    d = d_in & 255;
    h = h_in & 255;
    i_en       = en;
    i_cfg_vld  = vld;
    i_cfg_div  = CNT_W'(d);
    i_cfg_high = CNT_W'(h);
    acc      = vld && !m_pv;
    legal    = (d >= 2) && (h >= 1) && (h < d);
    do_apply = 1'b0;
    smp      = 2'b00;
    if (en) begin
      if (wave.size() == 0) begin
        for (int i = 0; i < m_div; i++) wave.push_back({(i == 0), (i < m_high)});
      end
      smp = wave.pop_front();
      if (wave.size() == 0) do_apply = m_pv;
    end else begin
      wave.delete();
      do_apply = m_pv;
    end
    if (do_apply) begin
      m_div  = m_pd;
      m_high = m_ph;
      m_pv   = 1'b0;
    end
    if (acc) begin
      if (legal) begin
        m_pv = 1'b1;
        m_pd = d;
        m_ph = h;
      end else begin
`ifdef DIV_CFG_CLAMP_EN
        nd = (d < 2) ? 2 : d;
        nh = (h == 0) ? 1 : h;
        if (nh >= nd) nh = nd - 1;
        m_pv = 1'b1;
        m_pd = nd;
        m_ph = nh;
`else
        nd = 0;
        nh = 0;
`endif
      end
    end
    e.ck  = smp[0];
    e.tk  = smp[1];
    e.err = acc && !legal;
    e.rdy = !m_pv;
    e.cur = m_div;
    exp_q.push_back(e);
    @(negedge i_clk);
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 0, 0, a);
  endtask

  // Advance until the next rising edge would sample the counter at position pos of its period.
  task automatic wait_pos(input int pos);
    bit a;
    int guard;
    guard = 0;
    while ((wave.size() != m_div - pos) && (guard < 300)) begin
      step(1'b1, 1'b0, 0, 0, a);
      guard++;
    end
    if (guard >= 300) chk("wait_pos_timeout", guard, 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_div_clk"}, int'(o_div_clk), 0);
    chk({tag, "_tick"},    int'(o_tick),    0);
    chk({tag, "_cfg_err"}, int'(o_cfg_err), 0);
    chk({tag, "_cfg_rdy"}, int'(o_cfg_rdy), 1);
    chk({tag, "_cur_div"}, int'(o_cur_div), DEF_DIV);
  endtask

  // Reset is asserted between edges, checked before any clock edge, and held across one rising edge.
  task automatic async_reset();
    #1;
    i_rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    exp_q.delete();
    @(negedge i_clk);
    i_rst_n = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("div_clk", int'(o_div_clk), int'(e.ck));
        chk("tick",    int'(o_tick),    int'(e.tk));
        chk("cfg_err", int'(o_cfg_err), int'(e.err));
        chk("cfg_rdy", int'(o_cfg_rdy), int'(e.rdy));
        chk("cur_div", int'(o_cur_div), e.cur);
      end
    end
  end

  initial begin : driver
    bit acc;
    int guard;
    int d, h;
    i_rst_n    = 1'b0;
    i_en       = 1'b0;
    i_cfg_vld  = 1'b0;
    i_cfg_div  = '0;
    i_cfg_high = '0;
    model_reset();
    repeat (3) @(negedge i_clk);
    check_reset_outputs("reset");
    i_rst_n = 1'b1;

    // Default 6/3 pattern.
    idle(14);

    // div=5 high=2 requested mid-period.
    wait_pos(1);
    step(1'b1, 1'b1, 5, 2, acc);
    idle(16);

    // Enable dropped mid-period for four cycles.
    wait_pos(1);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, 0, 0, acc);
    idle(12);

    // Illegal request.
    step(1'b1, 1'b1, 1, 1, acc);
    idle(14);

    // Request accepted on the wrap edge, second request held off while pending.
    wait_pos(m_div - 1);
    step(1'b1, 1'b1, 4, 1, acc);
    guard = 0;
    acc   = 1'b0;
    while (!acc && guard < 40) begin
      step(1'b1, 1'b1, 7, 5, acc);
      guard++;
    end
    if (guard >= 40) chk("second_cfg_timeout", guard, 0);
    idle(20);

    // Reset while a request is pending.
    step(1'b1, 1'b1, 9, 4, acc);
    idle(2);
    async_reset();
    idle(14);

    // Randomised traffic.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 49) == 0) d = 255;
      else d = int'($urandom_range(0, 12));
      h = int'($urandom_range(0, d + 1));
      step(($urandom_range(0, 9) != 0), ($urandom_range(0, 4) == 0), d, h, acc);
    end
    idle(4);

    repeat (2) @(negedge i_clk);
    if (exp_q.size() != 0) chk("scoreboard_drain", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
